dac_sample_player: RTL and testbench

- Upstream feeder for the 8-bit parallel R-2R `dac` stage.
- Accepts samples over a valid/ready stream and buffers them in a small FIFO.
- Releases one sample per programmable sample period onto a registered 8-bit bus wired directly to the ladder.
- Reports underruns when a period elapses with no buffered sample.

---
 rtl/dac_pkg.sv | 15 +
 rtl/dac_player_fifo.sv | 69 ++++++
 rtl/dac_sample_player.sv | 94 +++++++++
 tb/tb_dac_sample_player.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants for the R-2R DAC path: ladder width, midscale code and
// default buffer/divider sizes used by the player, the ladder and the benches.
package dac_pkg;

    localparam int              DAC_W         = 8;
    localparam logic [DAC_W-1:0] MIDSCALE     = 8'h80;
    localparam int              DEFAULT_DEPTH = 16;
    localparam int              DEFAULT_DIV_W = 16;

    // Width of an occupancy counter that must be able to hold the value 'depth'.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dac_player_fifo.sv
// Synchronous FIFO for the DAC sample player. The head entry is visible on
// rdata whenever the FIFO is not empty; push is ignored when full and pop is
// ignored when empty. Occupancy is tracked by a separate level counter so the
// pointers can wrap naturally modulo DEPTH (DEPTH must be a power of two).
module dac_player_fifo
    import dac_pkg::*;
#(
    parameter int DATA_W = DAC_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   pop,
    output logic [DATA_W-1:0]      rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Sample storage written on an accepted push.
    // NOTE: the storage array has no reset; level and the pointers define which
    // entries are valid, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; a flush on rst discards all entries.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_player.sv
// DAC sample player: buffers samples from a valid/ready stream and releases one
// per programmable period (div+1 clk cycles) onto a registered bus that drives
// the R-2R ladder directly. A period that elapses with nothing buffered raises a
// one-cycle underrun pulse and leaves the output at its last value.
// Optional build macro DAC_PLAYER_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun_cnt output counting underrun pulses.
module dac_sample_player
    import dac_pkg::*;
#(
    parameter int DATA_W = DAC_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DIV_W  = DEFAULT_DIV_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIV_W-1:0]       div,
    input  logic                   enable,
    output logic [DATA_W-1:0]      out,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]            underrun_cnt
`endif
);

    logic [DIV_W-1:0]  cnt;
    logic [DATA_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              tick;

    // No full-bypass: a pop in the same cycle does not reopen a full FIFO.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // '>=' lets a lowered div end the current period at once instead of wrapping.
    assign tick     = enable && (cnt >= div);
    // No empty-bypass: a sample pushed on a tick is only played at the next tick.
    assign pop      = tick && !fifo_empty;

    dac_player_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Period counter: held at zero while disabled, restarts on every tick.
    always_ff @(posedge clk) begin
        if (rst || !enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    // Output register to the ladder and the underrun pulse, both set on a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= DATA_W'(MIDSCALE);
            underrun <= 1'b0;
        end else begin
            if (pop) begin
                out <= head;
            end
            underrun <= tick && fifo_empty;
        end
    end

`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
    // Saturating underrun counter, stepped on the same edge that raises the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (tick && fifo_empty && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_sample_player.sv
// Self-checking bench for dac_sample_player: hand-derived vector table for the
// playback/underrun timing, directed corner sequences, and a randomized run
// against a queue-based reference model.
module tb_dac_sample_player;
    import dac_pkg::*;

    localparam int DATA_W = DAC_W;
    localparam int DEPTH  = DEFAULT_DEPTH;
    localparam int DIV_W  = DEFAULT_DIV_W;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DIV_W-1:0]  div;
    logic              enable;
    logic [DATA_W-1:0] out;
    logic              underrun;
    logic [LVL_W-1:0]  level;
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    always #5 clk = ~clk;

    dac_sample_player #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .DIV_W  (DIV_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .div      (div),
        .enable   (enable),
        .out      (out),
        .underrun (underrun),
        .level    (level)
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered samples plus an elapsed-cycle count.
    logic [7:0] mq[$];
    int         m_cnt;
    logic [7:0] m_out;
    logic       m_ur;
    int         m_ucnt;

    task automatic model_step(input logic r, input logic v, input logic [7:0] d,
                              input logic [DIV_W-1:0] dv, input logic en);
        bit accept, period_done;
        if (r) begin
            mq.delete();
            m_cnt  = 0;
            m_out  = MIDSCALE;
            m_ur   = 1'b0;
            m_ucnt = 0;
            return;
        end
        accept      = v && (mq.size() != DEPTH);
        period_done = en && (m_cnt >= int'(dv));
        m_ur        = period_done && (mq.size() == 0);
        if (m_ur && m_ucnt < 65535) m_ucnt++;
        if (period_done && mq.size() > 0) m_out = mq.pop_front();
        if (accept) mq.push_back(d);
        m_cnt = (!en || period_done) ? 0 : m_cnt + 1;
    endtask

    // Drive one cycle of inputs, advance the model, and settle past the edge.
    task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                       input logic [DIV_W-1:0] dv, input logic en);
        rst = r; in_valid = v; in_data = d; div = dv; enable = en;
        model_step(r, v, d, dv, en);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        int         dv;
        logic       en;
        logic [7:0] e_out;
        logic       e_ur;
        int         e_lvl;
    } vec_t;

    vec_t tbl[23];

    initial begin
        // Preload 10,20,30 then play at div=3: a new sample every 4 cycles,
        // followed by an underrun every 4 cycles with out held at 30.
        tbl[0]  = '{1, 8'h10, 3, 0, 8'h80, 0, 1};
        tbl[1]  = '{1, 8'h20, 3, 0, 8'h80, 0, 2};
        tbl[2]  = '{1, 8'h30, 3, 0, 8'h80, 0, 3};
        tbl[3]  = '{0, 8'h00, 3, 1, 8'h80, 0, 3};
        tbl[4]  = '{0, 8'h00, 3, 1, 8'h80, 0, 3};
        tbl[5]  = '{0, 8'h00, 3, 1, 8'h80, 0, 3};
        tbl[6]  = '{0, 8'h00, 3, 1, 8'h10, 0, 2};
        tbl[7]  = '{0, 8'h00, 3, 1, 8'h10, 0, 2};
        tbl[8]  = '{0, 8'h00, 3, 1, 8'h10, 0, 2};
        tbl[9]  = '{0, 8'h00, 3, 1, 8'h10, 0, 2};
        tbl[10] = '{0, 8'h00, 3, 1, 8'h20, 0, 1};
        tbl[11] = '{0, 8'h00, 3, 1, 8'h20, 0, 1};
        tbl[12] = '{0, 8'h00, 3, 1, 8'h20, 0, 1};
        tbl[13] = '{0, 8'h00, 3, 1, 8'h20, 0, 1};
        tbl[14] = '{0, 8'h00, 3, 1, 8'h30, 0, 0};
        tbl[15] = '{0, 8'h00, 3, 1, 8'h30, 0, 0};
        tbl[16] = '{0, 8'h00, 3, 1, 8'h30, 0, 0};
        tbl[17] = '{0, 8'h00, 3, 1, 8'h30, 0, 0};
        tbl[18] = '{0, 8'h00, 3, 1, 8'h30, 1, 0};
        tbl[19] = '{0, 8'h00, 3, 1, 8'h30, 0, 0};
        tbl[20] = '{0, 8'h00, 3, 1, 8'h30, 0, 0};
        tbl[21] = '{0, 8'h00, 3, 1, 8'h30, 0, 0};
        tbl[22] = '{0, 8'h00, 3, 1, 8'h30, 1, 0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; div = '0; enable = 1'b0;

        // Reset and idle.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("reset_out", out, 8'h80);
        check("reset_level", level, 0);
        check("reset_ready", in_ready, 1);
        check("reset_underrun", underrun, 0);
        for (int i = 0; i < 100; i++) begin
            cyc(0, 0, 8'(i), 16'(i % 4), 0);
            check("idle_out", out, 8'h80);
        end
        check("idle_underrun", underrun, 0);

        // Fill to DEPTH with playback disabled, then try one more push.
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'(i), 0, 0);
        check("fill_level", level, DEPTH);
        check("fill_ready", in_ready, 0);
        cyc(0, 1, 8'hEE, 0, 0);
        check("overfill_level", level, DEPTH);
        // Drain at div=0: samples come out in push order, then an underrun.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 0, 1);
            check("drain_out", out, i);
            check("drain_level", level, DEPTH - 1 - i);
            check("drain_underrun", underrun, 0);
        end
        cyc(0, 0, 0, 0, 1);
        check("drain_end_underrun", underrun, 1);
        check("drain_end_out", out, 8'h0F);

        // Vector table: playback rate and underrun cadence.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 23; i++) begin
            cyc(0, tbl[i].v, tbl[i].d, 16'(tbl[i].dv), tbl[i].en);
            check($sformatf("tbl%0d_out", i), out, tbl[i].e_out);
            check($sformatf("tbl%0d_underrun", i), underrun, tbl[i].e_ur);
            check($sformatf("tbl%0d_level", i), level, tbl[i].e_lvl);
        end
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
        check("tbl_underrun_cnt", underrun_cnt, 2);
`endif

        // Streaming at div=0: level stays 1, out lags the input by one push.
        cyc(1, 0, 0, 0, 0);
        for (int j = 0; j < 40; j++) begin
            cyc(0, 1, 8'(8'h40 + j), 0, 1);
            check("stream_level", level, 1);
            if (j == 0) begin
                check("stream_first_underrun", underrun, 1);
            end else begin
                check("stream_underrun", underrun, 0);
                check("stream_out", out, 8'(8'h40 + j - 1));
            end
        end

        // Lowering div from 100 to 5 with cnt=50 ends the period at once.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 8'hAA, 100, 0);
        for (int i = 0; i < 50; i++) cyc(0, 0, 0, 100, 1);
        check("lowdiv_hold_out", out, 8'h80);
        check("lowdiv_hold_level", level, 1);
        cyc(0, 0, 0, 5, 1);
        check("lowdiv_tick_out", out, 8'hAA);
        check("lowdiv_tick_level", level, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 5, 1);
            check("lowdiv_wait_underrun", underrun, 0);
        end
        cyc(0, 0, 0, 5, 1);
        check("lowdiv_next_underrun", underrun, 1);

        // Enable falling mid-period discards the partial period.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 8'hBB, 3, 0);
        cyc(0, 1, 8'hCC, 3, 0);
        cyc(0, 0, 0, 3, 1);
        cyc(0, 0, 0, 3, 1);
        cyc(0, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 3, 1);
            check("reen_wait_out", out, 8'h80);
        end
        cyc(0, 0, 0, 3, 1);
        check("reen_tick_out", out, 8'hBB);

        // Reset while holding eight samples flushes the FIFO.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 8'(8'hC0 + i), 0, 0);
        cyc(0, 0, 0, 0, 1);
        check("prerst_out", out, 8'hC0);
        check("prerst_level", level, 8);
        cyc(1, 0, 0, 0, 1);
        check("midrst_level", level, 0);
        check("midrst_out", out, 8'h80);
        check("midrst_ready", in_ready, 1);
        check("midrst_underrun", underrun, 0);

        // Randomized traffic against the reference model.
        cyc(1, 0, 0, 0, 0);
        for (int seg = 0; seg < 20; seg++) begin
            int         vprob;
            logic [15:0] dv;
            vprob = $urandom_range(0, 100);
            dv    = 16'($urandom_range(0, 4));
            for (int i = 0; i < 150; i++) begin
                logic v, en;
                v  = ($urandom_range(0, 99) < vprob);
                en = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 49) == 0) dv = 16'($urandom_range(0, 4));
                check("rand_ready", in_ready, (mq.size() != DEPTH));
                cyc(0, v, 8'($urandom), dv, en);
                check("rand_out", out, m_out);
                check("rand_underrun", underrun, m_ur);
                check("rand_level", level, mq.size());
`ifdef DAC_PLAYER_UNDERRUN_CNT_EN
                check("rand_underrun_cnt", underrun_cnt, m_ucnt);
`endif
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
